// File: rtl/uut_vector_sequencer.sv
// Streams a cipher test vector in from the SD reader, runs the UUT once with a cycle budget,
// and streams a fixed 21-byte result frame back out for write-back.
module uut_vector_sequencer #(
  parameter int RST_CYCLES = 4,
  parameter int TIMEOUT    = 4096,
  parameter int CNT_WIDTH  = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   in_byte,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [7:0]   out_byte,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         rst_uut,
  output logic [127:0] block_i_uut,
  output logic [127:0] key_uut,
  output logic         encdec_uut,
  input  logic [127:0] block_o_uut,
  input  logic         end_signal_uut,
  output logic         busy,
  output logic         timeout
);

  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam logic [RW-1:0]        RST_LAST = RW'(RST_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(TIMEOUT);

  typedef enum logic [1:0] {LOAD, UUT_RST, RUN, SEND} state_t;

  state_t               state;
  logic [5:0]           idx;
  logic [RW-1:0]        rst_cnt;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic [31:0]          cnt32;
  logic [167:0]         frame;

  assign cnt_next  = cnt + CNT_WIDTH'(1);
  assign cnt32     = 32'(cnt_next);
  assign rst_uut   = (state != RUN);
  assign busy      = (state != LOAD);
  assign out_valid = (state == SEND);
  assign out_byte  = frame[167:160];

  // The frame register holds status, result and count and shifts out MSB first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= LOAD;
      idx         <= '0;
      rst_cnt     <= '0;
      cnt         <= '0;
      frame       <= '0;
      in_ready    <= 1'b0;
      key_uut     <= '0;
      block_i_uut <= '0;
      encdec_uut  <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            if (idx == 6'd0)
              encdec_uut <= in_byte[0];
            else if (idx <= 6'd16)
              key_uut <= {key_uut[119:0], in_byte};
            else
              block_i_uut <= {block_i_uut[119:0], in_byte};
            if (idx == 6'd32) begin
              idx      <= '0;
              in_ready <= 1'b0;
              rst_cnt  <= '0;
              cnt      <= '0;
              state    <= UUT_RST;
            end else begin
              idx <= idx + 6'd1;
            end
          end
        end
        UUT_RST: begin
          if (rst_cnt == RST_LAST)
            state <= RUN;
          else
            rst_cnt <= rst_cnt + RW'(1);
        end
        RUN: begin
          cnt <= cnt_next;
          // Completion takes priority over a timeout landing on the same cycle.
          if (end_signal_uut) begin
            frame   <= {6'b0, encdec_uut, 1'b0, block_o_uut, cnt32};
            timeout <= 1'b0;
            idx     <= '0;
            state   <= SEND;
          end else if (cnt_next == CNT_MAX) begin
            frame   <= {6'b0, encdec_uut, 1'b1, 128'b0, cnt32};
            timeout <= 1'b1;
            idx     <= '0;
            state   <= SEND;
          end
        end
        SEND: begin
          if (out_ready) begin
            frame <= {frame[159:0], 8'h00};
            if (idx == 6'd20) begin
              idx      <= '0;
              in_ready <= 1'b1;
              state    <= LOAD;
            end else begin
              idx <= idx + 6'd1;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_uut_vector_sequencer.sv
// Directed bench for uut_vector_sequencer with a behavioural UUT that ends after a set number
// of run cycles and returns known Twofish vectors for the all-zero key.
module tb_uut_vector_sequencer;

  localparam int RST_CYCLES = 4;
  localparam int TIMEOUT    = 24;
  localparam logic [127:0] CT  = 128'h9F589F5C_F6122C32_B6BFEC2F_2AE8C35A;
  localparam logic [127:0] K3  = 128'h00010203_04050607_08090A0B_0C0D0E0F;
  localparam logic [127:0] B3  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] X3  = 128'h00102030_40506070_8090A0B0_C0D0E0F0;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [7:0]   in_byte = 8'h00;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [7:0]   out_byte;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         rst_uut;
  logic [127:0] block_i_uut;
  logic [127:0] key_uut;
  logic         encdec_uut;
  logic [127:0] block_o_uut;
  logic         end_signal_uut;
  logic         busy;
  logic         timeout;

  int compared = 0;
  int mismatched = 0;
  int end_after = 0;
  logic [7:0] uut_cyc;
  logic [167:0] frame;
  int n;

  uut_vector_sequencer #(.RST_CYCLES(RST_CYCLES), .TIMEOUT(TIMEOUT), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
    .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready),
    .rst_uut(rst_uut), .block_i_uut(block_i_uut), .key_uut(key_uut),
    .encdec_uut(encdec_uut), .block_o_uut(block_o_uut),
    .end_signal_uut(end_signal_uut), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // UUT stand-in: finishes on run cycle end_after (0 = never) with a table-driven result.
  always @(posedge clk) begin
    if (rst_uut) uut_cyc <= 8'd0;
    else         uut_cyc <= uut_cyc + 8'd1;
  end

  assign end_signal_uut = !rst_uut && (end_after != 0) && (int'(uut_cyc) + 1 == end_after);

  always_comb begin
    block_o_uut = block_i_uut ^ key_uut;
    if (!encdec_uut && key_uut == 128'h0 && block_i_uut == 128'h0) block_o_uut = CT;
    else if (encdec_uut && key_uut == 128'h0 && block_i_uut == CT) block_o_uut = 128'h0;
  end

  task automatic checkOutput(input string tag, input logic [167:0] obs, input logic [167:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int w = 0;
    in_byte  = b;
    in_valid = 1'b1;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) checkOutput("in_ready_wait", 168'(in_ready), 168'(1));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] cmd, input logic [127:0] key,
                               input logic [127:0] blk, input bit gaps);
    logic [127:0] k;
    logic [127:0] b;
    k = key;
    b = blk;
    send_byte(cmd);
    for (int i = 0; i < 32; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
      if (i < 16) begin
        send_byte(k[127:120]);
        k = k << 8;
      end else begin
        send_byte(b[127:120]);
        b = b << 8;
      end
    end
  endtask

  task automatic wait_run();
    int w = 0;
    while (rst_uut && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (rst_uut) checkOutput("run_wait", 168'(rst_uut), 168'(0));
  endtask

  task automatic recv_frame(input int nbytes, input int stall_at, input int stall_len,
                            input logic [167:0] exp, output logic [167:0] f);
    int w;
    f = '0;
    for (int i = 0; i < nbytes; i++) begin
      w = 0;
      while (!out_valid && w < 200) begin
        @(negedge clk);
        w++;
      end
      if (!out_valid) begin
        checkOutput("out_valid_wait", 168'(out_valid), 168'(1));
        out_ready = 1'b0;
        return;
      end
      if (i == stall_at) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          @(negedge clk);
          checkOutput("stall_byte", {159'(0), out_valid, out_byte},
                      {159'(0), 1'b1, exp[167 - 8*i -: 8]});
        end
      end
      out_ready = 1'b1;
      f = {f[159:0], out_byte};
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_uut_reset", 168'(rst_uut), 168'(1));
    checkOutput("regs_reset", {key_uut, block_i_uut}, '0);
    checkOutput("flags_reset", {encdec_uut, in_ready, out_valid, busy, timeout}, '0);
    checkOutput("out_byte_reset", 168'(out_byte), '0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("in_ready_load", {in_ready, busy}, 168'(2'b10));

    // 1: encrypt, end after 20 run cycles
    $display("[TB] encrypt vector");
    end_after = 20;
    applyStimulus(8'h00, 128'h0, 128'h0, 1'b0);
    n = 0;
    while (rst_uut && n < 50) begin
      n++;
      @(negedge clk);
    end
    checkOutput("rst_uut_cycles", 168'(n), 168'(RST_CYCLES));
    checkOutput("busy_run", 168'(busy), 168'(1));
    recv_frame(21, -1, 0, '0, frame);
    checkOutput("enc_frame", frame, {8'h00, CT, 32'h14});
    checkOutput("enc_after", {timeout, out_valid, rst_uut, in_ready}, 168'(4'b0011));

    // 2: timeout, UUT never ends
    $display("[TB] timeout vector");
    end_after = 0;
    applyStimulus(8'h00, K3, B3, 1'b0);
    recv_frame(21, -1, 0, '0, frame);
    checkOutput("to_frame", frame, {8'h01, 128'h0, 32'd24});
    checkOutput("to_after", {timeout, rst_uut}, 168'(2'b11));

    // 3: backpressure on both sides, timeout flag held through the next load
    $display("[TB] backpressure vector");
    end_after = 7;
    send_byte(8'h00);
    checkOutput("to_hold_load", 168'(timeout), 168'(1));
    for (int i = 0; i < 32; i++) begin
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
      send_byte(i < 16 ? K3[127 - 8*i -: 8] : B3[127 - 8*(i-16) -: 8]);
    end
    checkOutput("bp_key", 168'(key_uut), 168'(K3));
    checkOutput("bp_block", 168'(block_i_uut), 168'(B3));
    recv_frame(21, 8, 5, {8'h00, X3, 32'd7}, frame);
    checkOutput("bp_frame", frame, {8'h00, X3, 32'd7});
    checkOutput("bp_len", 168'(out_valid), 168'(0));

    // 4: end on first run cycle, and end exactly at the timeout limit
    $display("[TB] boundary vectors");
    end_after = 1;
    applyStimulus(8'h00, K3, B3, 1'b1);
    recv_frame(21, -1, 0, '0, frame);
    checkOutput("first_cycle_frame", frame, {8'h00, X3, 32'd1});
    end_after = TIMEOUT;
    applyStimulus(8'h00, K3, B3, 1'b0);
    recv_frame(21, -1, 0, '0, frame);
    checkOutput("limit_frame", frame, {8'h00, X3, 32'd24});
    checkOutput("limit_timeout", 168'(timeout), 168'(0));

    // 5: decrypt the ciphertext from the first vector
    $display("[TB] decrypt vector");
    end_after = 20;
    applyStimulus(8'h01, 128'h0, CT, 1'b0);
    wait_run();
    checkOutput("dec_mode_run", {encdec_uut, rst_uut}, 168'(2'b10));
    recv_frame(21, -1, 0, '0, frame);
    checkOutput("dec_frame", frame, {8'h02, 128'h0, 32'h14});

    // 6: reset mid-RUN and mid-SEND, then a clean vector
    $display("[TB] reset recovery");
    end_after = 0;
    applyStimulus(8'h01, K3, B3, 1'b0);
    wait_run();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_run_regs", {key_uut, block_i_uut}, '0);
    checkOutput("rst_run_flags", {rst_uut, encdec_uut, in_ready, out_valid, busy}, 168'(5'b10000));
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(8'h00, K3, B3, 1'b0);
    recv_frame(3, -1, 0, '0, frame);
    checkOutput("partial_frame", frame, {144'h0, 8'h01, 16'h0});
    rst = 1'b0;
    #1;
    checkOutput("rst_send", {timeout, out_valid, out_byte, rst_uut, busy}, 168'({1'b0, 1'b0, 8'h00, 1'b1, 1'b0}));
    @(negedge clk);
    rst = 1'b1;
    end_after = 20;
    applyStimulus(8'h00, 128'h0, 128'h0, 1'b0);
    recv_frame(21, -1, 0, '0, frame);
    checkOutput("recover_frame", frame, {8'h00, CT, 32'h14});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
